// File: rtl/sum_nibble_packer_if.sv
// Handshake bundle for sum_nibble_packer: the nibble input stream and the packed-word output stream.
// The master modport is the side that drives in_* and out_ready, typically a producer/consumer pair.
interface sum_nibble_packer_if #(
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned CNT_W   = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [3:0]             in_sum;
  logic                   in_cout;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NIBBLES-1:0]   out_word;
  logic [NIBBLES-1:0]     out_carry;
  logic [CNT_W-1:0]       out_len;
  logic                   out_ovf;

  modport master (
    output in_valid, in_sum, in_cout, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_carry, out_len, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, in_cout, in_last, out_ready,
    output in_ready, out_valid, out_word, out_carry, out_len, out_ovf
  );
endinterface

// File: rtl/sum_nibble_packer.sv
// Packs consecutive 4-bit adder results (sum + carry-out) LSB-first into a wide word
// and forwards it with per-nibble carries, a nibble count and an overflow summary.
module sum_nibble_packer #(
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sum_nibble_packer_if.slave  bus
);

  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if (NIBBLES < 2 || NIBBLES > 8) begin : g_bad_nibbles
    $error("sum_nibble_packer: NIBBLES must be in 2..8");
  end
  if ((1 << CNT_W) <= NIBBLES) begin : g_bad_cnt_w
    $error("sum_nibble_packer: CNT_W too narrow to hold NIBBLES");
  end

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [4*NIBBLES-1:0] word_q;
  logic [NIBBLES-1:0]   carry_q;
  logic [CNT_W-1:0]     len_q;
  logic                 ovf_q;
  logic                 valid_q;

  logic                 in_ready;
  logic                 accept_in;
  logic                 accept_out;
  logic [IDX_W-1:0]     wr_idx;
  logic                 closes;
  logic [4*NIBBLES-1:0] word_d;
  logic [NIBBLES-1:0]   carry_d;

  assign in_ready   = (state_q == COLLECT) ? 1'b1 : bus.out_ready;
  assign accept_in  = bus.in_valid && in_ready;
  assign accept_out = valid_q && bus.out_ready;

  // In FULL an accepted nibble always coincides with the old word leaving,
  // so it starts a fresh word at index 0 instead of extending the buffer.
  always_comb begin
    wr_idx  = (state_q == FULL) ? '0 : idx_q;
    word_d  = (state_q == FULL) ? '0 : word_q;
    carry_d = (state_q == FULL) ? '0 : carry_q;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (wr_idx == IDX_W'(k)) begin
        word_d[4*k +: 4] = bus.in_sum;
        carry_d[k]       = bus.in_cout;
      end
    end
    closes = bus.in_last || (wr_idx == IDX_W'(NIBBLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      word_q  <= '0;
      carry_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (accept_in) begin
      word_q  <= word_d;
      carry_q <= carry_d;
      if (closes) begin
        state_q <= FULL;
        idx_q   <= '0;
        len_q   <= CNT_W'(wr_idx) + CNT_W'(1);
        ovf_q   <= |carry_d;
        valid_q <= 1'b1;
      end else begin
        state_q <= COLLECT;
        idx_q   <= wr_idx + IDX_W'(1);
        len_q   <= '0;
        ovf_q   <= 1'b0;
        valid_q <= 1'b0;
      end
    end else if (accept_out) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      word_q  <= '0;
      carry_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_word  = word_q;
  assign bus.out_carry = carry_q;
  assign bus.out_len   = len_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_sum_nibble_packer.sv
// Randomized and directed bench for sum_nibble_packer against a packet-level reference model.
module tb_sum_nibble_packer;
  localparam int unsigned NIBBLES = 4;
  localparam int unsigned CNT_W   = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  sum_nibble_packer_if #(.NIBBLES(NIBBLES), .CNT_W(CNT_W)) bus ();

  sum_nibble_packer #(.NIBBLES(NIBBLES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    logic [3:0]  c;
    logic [3:0]  len;
    logic        ovf;
  } exp_t;

  exp_t       expq[$];
  logic [3:0] cur_s[$];
  logic       cur_c[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic close_packet();
    exp_t e;
    e.w = '0;
    e.c = '0;
    for (int k = 0; k < cur_s.size(); k++) begin
      e.w = e.w | (16'(cur_s[k]) << (4 * k));
      e.c[k] = cur_c[k];
    end
    e.len = 4'(cur_s.size());
    e.ovf = (e.c != 4'b0);
    expq.push_back(e);
    cur_s.delete();
    cur_c.delete();
  endtask

  // One clock cycle: drive, check against model, then advance model with the expected handshakes.
  task automatic step(input bit v, input logic [3:0] s, input bit c, input bit l, input bit r);
    bit exp_valid, exp_ready, ain, aout;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_sum    = s;
    bus.in_cout   = c;
    bus.in_last   = l;
    bus.out_ready = r;
    #1;
    exp_valid = (expq.size() != 0);
    exp_ready = !exp_valid || r;
    check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    if (exp_valid) begin
      check("out_word", 32'(bus.out_word), 32'(expq[0].w));
      check("out_carry", 32'(bus.out_carry), 32'(expq[0].c));
      check("out_len", 32'(bus.out_len), 32'(expq[0].len));
      check("out_ovf", 32'(bus.out_ovf), 32'(expq[0].ovf));
    end
    aout = exp_valid && r;
    ain  = v && exp_ready;
    if (aout) void'(expq.pop_front());
    if (ain) begin
      cur_s.push_back(s);
      cur_c.push_back(c);
      if (l || cur_s.size() == NIBBLES) close_packet();
    end
  endtask

  task automatic idle(input bit r);
    step(1'b0, 4'h0, 1'b0, 1'b0, r);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_word"}, 32'(bus.out_word), 32'd0);
    check({tag, "_carry"}, 32'(bus.out_carry), 32'd0);
    check({tag, "_len"}, 32'(bus.out_len), 32'd0);
    check({tag, "_ovf"}, 32'(bus.out_ovf), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_cout   = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #22;
    check_zero("reset");
    rst_n = 1'b1;

    // Full word of four, no carries
    step(1, 4'h1, 0, 0, 1);
    step(1, 4'hF, 0, 0, 1);
    step(1, 4'hD, 0, 0, 1);
    step(1, 4'h9, 0, 0, 1);
    idle(0);
    check("t1_word", 32'(bus.out_word), 32'h9DF1);
    check("t1_len", 32'(bus.out_len), 32'd4);
    check("t1_ovf", 32'(bus.out_ovf), 32'd0);
    idle(1);

    // Carry in nibble 0
    step(1, 4'hE, 1, 0, 1);
    step(1, 4'h3, 0, 0, 1);
    step(1, 4'h0, 0, 0, 1);
    step(1, 4'h0, 0, 0, 1);
    idle(0);
    check("t2_word", 32'(bus.out_word), 32'h003E);
    check("t2_carry", 32'(bus.out_carry), 32'b0001);
    check("t2_ovf", 32'(bus.out_ovf), 32'd1);
    idle(1);

    // Early close with in_last
    step(1, 4'h5, 0, 0, 1);
    step(1, 4'h6, 0, 1, 1);
    idle(0);
    check("t3_word", 32'(bus.out_word), 32'h0065);
    check("t3_len", 32'(bus.out_len), 32'd2);
    check("t3_carry", 32'(bus.out_carry), 32'd0);
    idle(1);

    // Backpressure: word held, extra inputs refused, then simultaneous transfer
    for (int i = 0; i < 4; i++) step(1, 4'(i + 7), i[0], 0, 0);
    for (int i = 0; i < 5; i++) step(1, 4'hA, 1, 0, 0);
    step(1, 4'hB, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 4'(i + 2), 0, 0, 1);
    idle(1);

    // Back-to-back stream of three words
    for (int i = 0; i < 12; i++) step(1, 4'($urandom), 1'($urandom), 0, 1);
    idle(1);
    idle(1);

    // Reset mid-packet
    step(1, 4'hC, 1, 0, 1);
    step(1, 4'hD, 1, 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    expq.delete();
    cur_s.delete();
    cur_c.delete();
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b1;
    step(1, 4'h4, 0, 0, 1);
    step(1, 4'h3, 0, 0, 1);
    step(1, 4'h2, 0, 0, 1);
    step(1, 4'h1, 0, 0, 1);
    idle(0);
    check("t6_word", 32'(bus.out_word), 32'h1234);
    check("t6_carry", 32'(bus.out_carry), 32'd0);
    idle(1);

    // Randomized traffic with random backpressure and early closes
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom),
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) < 7));
    for (int i = 0; i < 4; i++) idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
